// File: rtl/dest_reg_bank.sv
// One-hot-addressed slot bank; full bank moves to a registered valid/ready output one edge after the last load.
// No upstream stall: loads to full slots while the output is stalled set sticky err_o. DEST_BANK_PARITY_EN adds word_par_o.
module dest_reg_bank #(
  parameter int WIDTH = 4,
  parameter int NREG  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ldd_i,
  input  logic [NREG-1:0]       sel_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  err_clr_i,
  input  logic                  word_ready_i,
  output logic [NREG*WIDTH-1:0] word_out_o,
`ifdef DEST_BANK_PARITY_EN
  output logic                  word_par_o,
`endif
  output logic                  word_valid_o,
  output logic [NREG-1:0]       filled_o,
  output logic                  err_o
);

  logic [NREG*WIDTH-1:0] bank_q, bank_d;
  logic [NREG*WIDTH-1:0] word_q, word_d;
  logic [NREG-1:0]       filled_q, filled_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  onehot, xfer, hit, load_ok;
`ifdef DEST_BANK_PARITY_EN
  logic                  par_q, par_d;
`endif

  always_comb begin
    onehot  = (sel_i != '0) && ((sel_i & (sel_i - NREG'(1))) == '0);
    xfer    = (&filled_q) && (!valid_q || word_ready_i);
    hit     = |(sel_i & filled_q);
    // An xfer edge empties the bank, so a load landing on it never overflows.
    load_ok = ldd_i && onehot && (xfer || !hit);

    bank_d = bank_q;
    for (int i = 0; i < NREG; i++) begin
      if (load_ok && sel_i[i]) bank_d[i*WIDTH +: WIDTH] = din_i;
    end

    filled_d = xfer ? '0 : filled_q;
    if (load_ok) filled_d = filled_d | sel_i;

    word_d  = xfer ? bank_q : word_q;
    valid_d = valid_q;
    if (xfer) valid_d = 1'b1;
    else if (valid_q && word_ready_i) valid_d = 1'b0;

    if (ldd_i && !load_ok) err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else err_d = err_q;
`ifdef DEST_BANK_PARITY_EN
    par_d = xfer ? ^bank_q : par_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank_q   <= '0;
      word_q   <= '0;
      filled_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef DEST_BANK_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      bank_q   <= bank_d;
      word_q   <= word_d;
      filled_q <= filled_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef DEST_BANK_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign word_out_o   = word_q;
  assign word_valid_o = valid_q;
  assign filled_o     = filled_q;
  assign err_o        = err_q;
`ifdef DEST_BANK_PARITY_EN
  assign word_par_o   = par_q;
`endif

endmodule
